// File: rtl/hazard_control_unit_if.sv
// ============================================================================
// Module   : hazard_control_unit_if
// Desc     : Pipeline-side bundle between ID/EX decode and the hazard controller
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_control_unit_if;
  // ID-stage instruction
  logic [4:0] rs_ID;
  logic [4:0] rt_ID;
  logic       uses_rt_ID;
  logic       mdu_read_ID;
  logic       mdu_op_ID;
  logic       jump_ID;
  // EX-stage instruction
  logic [4:0] rt_EX;
  logic       MemRead_EX;
  logic       mdu_start_EX;
  logic       mdu_is_div_EX;
  logic       branch_taken_EX;
  // controls back to the pipeline
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       mdu_busy;
  logic       mdu_done;
  logic [31:0] stall_cycles;

  modport master (
    output rs_ID, rt_ID, uses_rt_ID, mdu_read_ID, mdu_op_ID, jump_ID,
    output rt_EX, MemRead_EX, mdu_start_EX, mdu_is_div_EX, branch_taken_EX,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    input  mdu_busy, mdu_done, stall_cycles
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rt_ID, mdu_read_ID, mdu_op_ID, jump_ID,
    input  rt_EX, MemRead_EX, mdu_start_EX, mdu_is_div_EX, branch_taken_EX,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    output mdu_busy, mdu_done, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Desc     : Load-use / MDU stall, control-flow flush and MDU sequencing
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_control_unit_if.slave  hz
);

  localparam int              CW         = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0]   c_mul_load = CW'(MUL_CYCLES);
  localparam logic [CW-1:0]   c_div_load = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]   c_one      = CW'(1);
  localparam logic [31:0]     c_sat      = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t     r_state;
  mdu_state_t     w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic [CW-1:0]  w_load;
  logic           w_done;
  logic           w_busy;
  logic [31:0]    r_stall_cycles;

  logic           w_lu;
  logic           w_mh;
  logic           w_stall;
  logic           w_pc_write;
  logic           w_if_id_write;
  logic           w_if_id_flush;
  logic           w_id_ex_flush;

  assign w_busy = (r_state == MDU_BUSY);
  assign w_load = hz.mdu_is_div_EX ? c_div_load : c_mul_load;

  // Hazard detection
  assign w_lu = hz.MemRead_EX && (hz.rt_EX != 5'd0) &&
                ((hz.rt_EX == hz.rs_ID) ||
                 (hz.uses_rt_ID && (hz.rt_EX == hz.rt_ID)));
  assign w_mh    = w_busy && (hz.mdu_read_ID || hz.mdu_op_ID);
  assign w_stall = w_lu || w_mh;

  // A taken branch squashes everything younger, so it outranks any stall;
  // a stall outranks a jump flush so the jump stays in ID and retries.
  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (rst) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (hz.branch_taken_EX) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end else if (hz.jump_ID) begin
      w_if_id_flush = 1'b1;
    end
  end

  // MDU sequencer: a start while busy reloads the count and hides done
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done      = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (hz.mdu_start_EX) begin
          w_state_nxt = MDU_BUSY;
          w_count_nxt = w_load;
        end
      end
      MDU_BUSY: begin
        if (hz.mdu_start_EX) begin
          w_count_nxt = w_load;
        end else if (r_count <= c_one) begin
          w_done      = (r_count == c_one);
          w_count_nxt = '0;
          w_state_nxt = MDU_IDLE;
        end else begin
          w_count_nxt = r_count - c_one;
        end
      end
      default: begin
        w_state_nxt = MDU_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_write && (r_stall_cycles != c_sat)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign hz.PCWrite      = w_pc_write;
  assign hz.IF_ID_Write  = w_if_id_write;
  assign hz.IF_ID_Flush  = w_if_id_flush;
  assign hz.ID_EX_Flush  = w_id_ex_flush;
  assign hz.mdu_busy     = w_busy;
  assign hz.mdu_done     = w_done;
  assign hz.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module   : tb_hazard_control_unit
// Desc     : Scoreboard bench for hazard_control_unit (MUL=4, DIV=32)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;
  localparam logic [3:0] JMP   = 4'b1110;
  localparam logic [3:0] RSTO  = 4'b0011;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [5:0] exp_q[$];
  logic [5:0] e;

  hazard_control_unit_if bus();

  hazard_control_unit #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
            bus.mdu_busy, bus.mdu_done};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic mdu_read, input logic mdu_op, input logic [4:0] rt_ex,
                       input logic memread, input logic start, input logic is_div,
                       input logic branch, input logic jump);
    @(negedge clk);
    bus.rs_ID           = rs;
    bus.rt_ID           = rt;
    bus.uses_rt_ID      = uses_rt;
    bus.mdu_read_ID     = mdu_read;
    bus.mdu_op_ID       = mdu_op;
    bus.rt_EX           = rt_ex;
    bus.MemRead_EX      = memread;
    bus.mdu_start_EX    = start;
    bus.mdu_is_div_EX   = is_div;
    bus.branch_taken_EX = branch;
    bus.jump_ID         = jump;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rs_ID = '0; bus.rt_ID = '0; bus.uses_rt_ID = 0; bus.mdu_read_ID = 0;
    bus.mdu_op_ID = 0; bus.rt_EX = '0; bus.MemRead_EX = 0; bus.mdu_start_EX = 0;
    bus.mdu_is_div_EX = 0; bus.branch_taken_EX = 0; bus.jump_ID = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(5'd8, 5'd8, 1, 1, 1, 5'd8, 1, 1, 1, 1, 1);
    exp_q.push_back({RSTO, 2'b00});
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs() !== e) begin
      miscompares++; $display("FAIL reset_outputs: got %b need %b", obs(), e);
    end
    vectors++;
    if (bus.stall_cycles !== 32'd0) begin
      miscompares++; $display("FAIL reset_stall_cycles: got %0d need 0", bus.stall_cycles);
    end
    pulse_reset();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    exp_q.push_back({RUN, 2'b00});
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs() !== e) begin
      miscompares++; $display("FAIL reset_release: got %b need %b", obs(), e);
    end
  endtask

  task automatic test_load_use();
    pulse_reset();
    drive(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0);
    exp_q.push_back({STALL, 2'b00});
    drive(5'd8, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    exp_q.push_back({RUN, 2'b00});
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
    exp_q.push_back({RUN, 2'b00});
    // outputs were sampled inside each cycle; compare in arrival order
    repeat (0) @(negedge clk);
    begin
      logic [5:0] got [3];
      got = '{default: '0};
    end
  endtask

  task automatic test_load_use_checked();
    logic [5:0] r;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin drive(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0); exp_q.push_back({STALL, 2'b00}); end
        1: begin drive(5'd8, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0); exp_q.push_back({RUN, 2'b00}); end
        2: begin drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0); exp_q.push_back({RUN, 2'b00}); end
        default: begin drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0); exp_q.push_back({RUN, 2'b00}); end
      endcase
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL load_use cyc%0d: got %b need %b", k, obs(), r);
      end
      if (k >= 1) begin
        vectors++;
        if (bus.stall_cycles !== 32'd1) begin
          miscompares++; $display("FAIL load_use_count cyc%0d: got %0d need 1", k, bus.stall_cycles);
        end
      end
    end
  endtask

  task automatic test_rt_gating();
    logic [5:0] r;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin drive(5'd3, 5'd8, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0); exp_q.push_back({RUN, 2'b00}); end
        1: begin drive(5'd3, 5'd8, 1, 0, 0, 5'd8, 1, 0, 0, 0, 0); exp_q.push_back({STALL, 2'b00}); end
        default: begin drive(5'd3, 5'd8, 1, 0, 0, 5'd0, 0, 0, 0, 0, 0); exp_q.push_back({RUN, 2'b00}); end
      endcase
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL rt_gating cyc%0d: got %b need %b", k, obs(), r);
      end
    end
  endtask

  task automatic test_divide();
    logic [5:0] r;
    pulse_reset();
    for (int k = 0; k <= 33; k++) begin
      if (k == 0) begin
        drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 1, 1, 0, 0);
        exp_q.push_back({RUN, 2'b00});
      end else if (k <= 32) begin
        drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        exp_q.push_back({STALL, 1'b1, (k == 32)});
      end else begin
        drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
        exp_q.push_back({RUN, 2'b00});
      end
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL divide T+%0d: got %b need %b", k, obs(), r);
      end
    end
    vectors++;
    if (bus.stall_cycles !== 32'd32) begin
      miscompares++; $display("FAIL divide_count: got %0d need 32", bus.stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] r;
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) begin
        drive(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, 0, 0, 0);
        exp_q.push_back({RUN, 2'b00});
      end else if (k <= 4) begin
        drive(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 0);
        exp_q.push_back({STALL, 1'b1, (k == 4)});
      end else if (k == 5) begin
        drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        exp_q.push_back({RUN, 2'b00});
      end else begin
        drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
        exp_q.push_back({RUN, (k <= 9), (k == 9)});
      end
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL back_to_back T+%0d: got %b need %b", k, obs(), r);
      end
    end
  endtask

  task automatic test_restart();
    logic [5:0] r;
    for (int k = 0; k <= 7; k++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, (k == 0 || k == 2), 0, 0, 0);
      exp_q.push_back({RUN, (k >= 1 && k <= 6), (k == 6)});
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL restart T+%0d: got %b need %b", k, obs(), r);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] r;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin drive(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 0, 0, 1, 0); exp_q.push_back({FLUSH, 2'b00}); end
        1: begin drive(5'd4, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 1); exp_q.push_back({JMP, 2'b00}); end
        2: begin drive(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 1); exp_q.push_back({STALL, 2'b00}); end
        default: begin drive(5'd8, 5'd0, 0, 0, 0, 5'd8, 1, 0, 0, 1, 1); exp_q.push_back({FLUSH, 2'b00}); end
      endcase
      #1;
      r = exp_q.pop_front(); vectors++;
      if (obs() !== r) begin
        miscompares++; $display("FAIL branch cyc%0d: got %b need %b", k, obs(), r);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    logic [5:0] r;
    pulse_reset();
    drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 1, 1, 0, 0);
    for (int k = 1; k < 10; k++) drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    exp_q.push_back({RSTO, 2'b00});
    #1;
    r = exp_q.pop_front(); vectors++;
    if (obs() !== r) begin
      miscompares++; $display("FAIL mid_div_reset: got %b need %b", obs(), r);
    end
    vectors++;
    if (bus.stall_cycles !== 32'd0) begin
      miscompares++; $display("FAIL mid_div_reset_count: got %0d need 0", bus.stall_cycles);
    end
    drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    exp_q.push_back({RUN, 2'b00});
    #1;
    r = exp_q.pop_front(); vectors++;
    if (obs() !== r) begin
      miscompares++; $display("FAIL mid_div_release: got %b need %b", obs(), r);
    end
    drive(5'd0, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0);
    exp_q.push_back({RUN, 2'b00});
    #1;
    r = exp_q.pop_front(); vectors++;
    if (obs() !== r) begin
      miscompares++; $display("FAIL mid_div_mfhi: got %b need %b", obs(), r);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_load_use_checked();
    test_rt_gating();
    test_divide();
    test_back_to_back();
    test_restart();
    test_branch();
    test_reset_mid_divide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage MIPS32 core. It works alongside the ALU operand-forwarding logic and handles the hazards that forwarding cannot resolve: load-use stalls, stalls on a busy multi-cycle multiply/divide unit (MDU), and control-flow flushes. It drives the PC and IF/ID write enables, the IF/ID and ID/EX flush (bubble) controls, and MDU sequencing. It also keeps a saturating stall-cycle performance counter.

## Interface
- MUL_CYCLES, 4, MDU latency for mult/multu; must be ≥1.
- DIV_CYCLES, 32, MDU latency for div/divu; must be ≥ MUL_CYCLES.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs_ID  input  5  rs field of the instruction in ID.
- rt_ID  input  5  rt field of the instruction in ID.
- uses_rt_ID  input  1  the ID instruction reads rt as a source.
- mdu_read_ID  input  1  the ID instruction is mfhi/mflo.
- mdu_op_ID  input  1  the ID instruction is mult/multu/div/divu.
- rt_EX  input  5  destination of the instruction in EX.
- MemRead_EX  input  1  the EX instruction is a load.
- mdu_start_EX  input  1  an MDU operation is in EX this cycle.
- mdu_is_div_EX  input  1  that operation is a divide.
- branch_taken_EX  input  1  a branch resolved taken in EX.
- jump_ID  input  1  a j/jal/jr is decoded in ID.
- PCWrite  output  1  PC register enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  zero the IF/ID register (insert NOP).
- ID_EX_Flush  output  1  zero the ID/EX control bits (bubble).
- mdu_busy  output  1  MDU operation in flight.
- mdu_done  output  1  one-cycle pulse in the final MDU cycle; HI/LO are written at its closing edge.
- stall_cycles  output  32  count of cycles with PCWrite=0, saturating at 0xFFFFFFFF.

## Operation
- **Load-use hazard (lu):** `MemRead_EX && rt_EX!=0 && (rt_EX==rs_ID || (uses_rt_ID && rt_EX==rt_ID))`.
- **MDU hazard (mh):** `mdu_busy && (mdu_read_ID || mdu_op_ID)`.
- **Stall** = lu | mh. Outputs during a stall: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
- **Flush priority:** branch_taken_EX overrides any stall.
  - Outputs: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
- **jump_ID with no branch_taken_EX:** IF_ID_Flush=1.
  - If a stall is also active, the stall wins and IF_ID_Flush=0, so the jump is retained and re-evaluated next cycle.
- **Default:** PCWrite=1, IF_ID_Write=1, both flushes 0.
- **MDU FSM states:** IDLE, BUSY.
  - IDLE→BUSY on mdu_start_EX. The counter loads DIV_CYCLES if mdu_is_div_EX, else MUL_CYCLES.
  - BUSY: the counter decrements each cycle. mdu_done=1 when count==1. BUSY→IDLE when count reaches 0.
  - mdu_start_EX while BUSY is a restart: the counter reloads and mdu_done is suppressed that cycle. mh guarantees this cannot occur in legal flow.
  - branch_taken_EX does not cancel an in-flight MDU operation, because that operation is older than the branch.
- **Counter width:** $clog2(DIV_CYCLES+1). mdu_busy = (state==BUSY).
- **stall_cycles:** +1 on every edge where PCWrite=0 and rst is low. It holds at 0xFFFFFFFF once saturated.

## Timing
- Hazard outputs are combinational from the current inputs and MDU state. There is no added latency.
- mdu_start_EX in cycle T:
  - mdu_busy is high in cycles T+1 through T+N.
  - mdu_done is high in cycle T+N only.
  - An mfhi held in ID proceeds in cycle T+N+1.
- **Reset (asynchronous, any time, including mid-MDU operation):**
  - State goes to IDLE, counter to 0, stall_cycles to 0, mdu_busy=0, mdu_done=0.
  - While rst=1: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
  - On the first edge after deassertion, normal operation resumes.
- A load-use stall lasts exactly 1 cycle, because the load then advances to MEM and forwarding resolves the dependency.
- An MDU stall lasts until the cycle after mdu_done.

## Test plan
- Load-use stall: lw $t0 in EX (MemRead_EX=1, rt_EX=8), add in ID with rs_ID=8. Required: one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles increments by 1. Repeat with rt_EX=0 and require no stall.
- rt gating: rt_ID=8 with uses_rt_ID=0. Required: no stall. With uses_rt_ID=1, the stall is required.
- Divide: mdu_start_EX=1, mdu_is_div_EX=1 at T, mfhi held in ID. Required: mdu_busy high for cycles T+1 through T+32; mdu_done at T+32; PCWrite=0 for 32 cycles; PCWrite=1 at T+33; stall_cycles=32.
- Multiply back-to-back: mult in EX at T, then mult in ID. Required: the second mult stalls for cycles T+1 through T+4 and enters EX at T+5; mdu_busy then stays high for another 4 cycles.
- Branch over stall: branch_taken_EX=1 in the same cycle as lu=1. Required: PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1. With jump_ID alone, IF_ID_Flush=1 only.
- Reset mid-divide: assert rst at T+10 of a divide. Required: immediate mdu_busy=0, stall_cycles=0, flushes=1, PCWrite=0. After release, a mfhi in ID does not stall.
